// File: rtl/gf180mcu_ocd_ip_sram_pkg.sv
// Shared types and elaboration helpers for the banked SRAM subsystem.
package gf180mcu_ocd_ip_sram_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Bank-select width never collapses to zero, even for a single bank.
  function automatic int sel_width(input int nbanks);
    return (nbanks < 2) ? 1 : clog2(nbanks);
  endfunction

endpackage

// File: rtl/gf180mcu_ocd_ip_sram__bank_model.sv
// Behavioural DEPTH x WIDTH bank with macro-style active-low controls; Q holds
// its value except on a read cycle, so it can be swapped for the hard macro.
module gf180mcu_ocd_ip_sram__bank_model
  import gf180mcu_ocd_ip_sram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CEN,
  input  logic             GWEN,
  input  logic [WIDTH-1:0] WEN,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // WEN bit low writes that bit; high bits keep their stored value.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/gf180mcu_ocd_ip_sram__sram_banked.sv
// Banked single-port SRAM: request decode, post-reset clear sweep, read
// pipeline with bank tag and optional output register.
module gf180mcu_ocd_ip_sram__sram_banked
  import gf180mcu_ocd_ip_sram_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 512,
  parameter int NBANKS         = 2,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = clog2(DEPTH * NBANKS),
  localparam int IW            = clog2(DEPTH),
  localparam int BW            = sel_width(NBANKS)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WE,
  input  logic [AW-1:0]    REQ_ADDR,
  input  logic [WIDTH-1:0] REQ_WMASK,
  input  logic [WIDTH-1:0] REQ_D,
  output logic             RSP_VALID,
  output logic [WIDTH-1:0] RSP_Q,
  output logic             INIT_DONE,
  output state_t           dbg_state
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [31:0] TOTAL_U = 32'(DEPTH * NBANKS);

  state_t         state;
  state_t         state_nx;
  logic [IW-1:0]  clr_idx;
  logic           last_idx;
  logic           accept;

  assign last_idx  = (clr_idx == IW'(DEPTH - 1));
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state   <= ST_RESET;
      clr_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR && !last_idx) begin
        clr_idx <= clr_idx + 1'b1;
      end else begin
        clr_idx <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RESET: state_nx = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      ST_CLEAR: if (last_idx) state_nx = ST_RUN;
      ST_RUN:   state_nx = ST_RUN;
      default:  state_nx = ST_RESET;
    endcase
  end

  // Handshake: a request transfers on a rising CLK where REQ_VALID and
  // REQ_READY are both high; REQ_READY is high only in RUN, independent of REQ_VALID.
  assign REQ_READY = (state == ST_RUN);
  assign INIT_DONE = (state == ST_RUN);
  assign accept    = REQ_VALID & REQ_READY;

  logic [31:0]   addr_ext;
  logic [31:0]   bank_full;
  logic [31:0]   idx_full;
  logic [BW-1:0] req_bank;
  logic [IW-1:0] req_idx;
  logic          in_range;
  logic          unused_hi;

  assign addr_ext  = 32'(REQ_ADDR);
  assign bank_full = addr_ext / DEPTH_U;
  assign idx_full  = addr_ext % DEPTH_U;
  assign req_bank  = bank_full[BW-1:0];
  assign req_idx   = idx_full[IW-1:0];
  assign in_range  = (addr_ext < TOTAL_U);
  assign unused_hi = &{1'b0, bank_full[31:BW], idx_full[31:IW]};

  logic [NBANKS-1:0] cen;
  logic              gwen;
  logic [WIDTH-1:0]  wen;
  logic [IW-1:0]     bank_a;
  logic [WIDTH-1:0]  bank_d;
  logic [WIDTH-1:0]  bank_q [NBANKS];

  // The sweep drives every bank at once; a user access enables only its bank.
  always_comb begin
    cen    = '1;
    gwen   = 1'b1;
    wen    = '1;
    bank_a = req_idx;
    bank_d = REQ_D;
    if (state == ST_CLEAR) begin
      cen    = '0;
      gwen   = 1'b0;
      wen    = '0;
      bank_a = clr_idx;
      bank_d = '0;
    end else if (accept && in_range) begin
      for (int b = 0; b < NBANKS; b++) begin
        if (req_bank == BW'(b)) cen[b] = 1'b0;
      end
      gwen = !REQ_WE;
      wen  = ~REQ_WMASK;
    end
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    gf180mcu_ocd_ip_sram__bank_model #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .CLK  (CLK),
      .CEN  (cen[g]),
      .GWEN (gwen),
      .WEN  (wen),
      .A    (bank_a),
      .D    (bank_d),
      .Q    (bank_q[g])
    );
  end

  logic             rd_v1;
  logic [BW-1:0]    rd_bank;
  logic             rd_oor;
  logic             rd_seen;
  logic [WIDTH-1:0] rd_data;

  // rd_seen masks the macro Q, which is unknown until the first read after reset.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      rd_v1   <= 1'b0;
      rd_bank <= '0;
      rd_oor  <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      rd_v1 <= accept & !REQ_WE;
      if (accept && !REQ_WE) begin
        rd_seen <= 1'b1;
        rd_oor  <= !in_range;
        if (in_range) rd_bank <= req_bank;
      end
    end
  end

  assign rd_data = (!rd_seen || rd_oor) ? '0 : bank_q[rd_bank];

  if (OUT_REG != 0) begin : g_oreg
    logic             v2;
    logic [WIDTH-1:0] q2;
    always_ff @(posedge CLK) begin
      if (!RESETN) begin
        v2 <= 1'b0;
        q2 <= '0;
      end else begin
        v2 <= rd_v1;
        if (rd_v1) q2 <= rd_data;
      end
    end
    assign RSP_VALID = v2;
    assign RSP_Q     = q2;
  end else begin : g_direct
    assign RSP_VALID = rd_v1;
    assign RSP_Q     = rd_data;
  end

endmodule

// File: tb/tb_gf180mcu_ocd_ip_sram__sram_banked.sv
// Bench for the banked SRAM: a 2-bank latency-1 instance and a 3-bank
// output-registered instance, checked against flat word-array models.
module tb_gf180mcu_ocd_ip_sram__sram_banked;
  import gf180mcu_ocd_ip_sram_pkg::*;

  localparam int T0 = 1024;
  localparam int T1 = 1536;

  logic clk;
  logic resetn;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic        valid0, we0, ready0, rsp_v0, init0;
  logic [9:0]  addr0;
  logic [7:0]  mask0, d0, rsp_q0;
  state_t      st0;
  logic        valid1, we1, ready1, rsp_v1, init1;
  logic [10:0] addr1;
  logic [7:0]  mask1, d1, rsp_q1;
  state_t      st1;

  logic [7:0] mem0 [T0];
  logic [7:0] mem1 [T1];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         due_q0[$];
  int         due_q1[$];

  gf180mcu_ocd_ip_sram__sram_banked #(
    .WIDTH(8), .DEPTH(512), .NBANKS(2), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .CLK(clk), .RESETN(resetn), .REQ_VALID(valid0), .REQ_READY(ready0),
    .REQ_WE(we0), .REQ_ADDR(addr0), .REQ_WMASK(mask0), .REQ_D(d0),
    .RSP_VALID(rsp_v0), .RSP_Q(rsp_q0), .INIT_DONE(init0), .dbg_state(st0)
  );

  gf180mcu_ocd_ip_sram__sram_banked #(
    .WIDTH(8), .DEPTH(512), .NBANKS(3), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .CLK(clk), .RESETN(resetn), .REQ_VALID(valid1), .REQ_READY(ready1),
    .REQ_WE(we1), .REQ_ADDR(addr1), .REQ_WMASK(mask1), .REQ_D(d1),
    .RSP_VALID(rsp_v1), .RSP_Q(rsp_q1), .INIT_DONE(init1), .dbg_state(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < T0; i++) mem0[i] = 8'h00;
    for (int i = 0; i < T1; i++) mem1[i] = 8'h00;
  endtask

  // driver: one request for one instance; model updated in program order
  task automatic req(input int inst, input logic we, input int addr,
                     input logic [7:0] mask, input logic [7:0] d);
    if (inst == 0) begin
      chk("ready0_in_run", ready0, 1);
      valid0 = 1'b1; we0 = we; addr0 = addr[9:0]; mask0 = mask; d0 = d;
      if (we) mem0[addr] = (mem0[addr] & ~mask) | (d & mask);
      else begin
        exp_q0.push_back(mem0[addr]);
        due_q0.push_back(cyc + 1);
      end
    end else begin
      chk("ready1_in_run", ready1, 1);
      valid1 = 1'b1; we1 = we; addr1 = addr[10:0]; mask1 = mask; d1 = d;
      if (we) begin
        if (addr < T1) mem1[addr] = (mem1[addr] & ~mask) | (d & mask);
      end else begin
        exp_q1.push_back((addr < T1) ? mem1[addr] : 8'h00);
        due_q1.push_back(cyc + 2);
      end
    end
    @(posedge clk); #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // counts not-ready cycles following the first edge with RESETN high
  task automatic count_clear();
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ready0 && ready1) break;
      if (!ready0) n0++;
      if (!ready1) n1++;
      if (init0 || init1) chk("init_early", {init0, init1}, 0);
    end
    chk("clear_cycles0", n0, 512);
    chk("clear_cycles1", n1, 512);
    chk("init_done0", init0, 1);
    chk("init_done1", init1, 1);
    @(posedge clk); #1;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (due_q0.size() > 0 && due_q0[0] < cyc) begin
      chk("rsp0_missing", 0, 1);
      void'(exp_q0.pop_front());
      void'(due_q0.pop_front());
    end
    if (rsp_v0 === 1'b1) begin
      if (exp_q0.size() == 0) chk("rsp0_unexpected", 1, 0);
      else begin
        chk("rsp0_data", rsp_q0, exp_q0.pop_front());
        chk("rsp0_latency", cyc, due_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (due_q1.size() > 0 && due_q1[0] < cyc) begin
      chk("rsp1_missing", 0, 1);
      void'(exp_q1.pop_front());
      void'(due_q1.pop_front());
    end
    if (rsp_v1 === 1'b1) begin
      if (exp_q1.size() == 0) chk("rsp1_unexpected", 1, 0);
      else begin
        chk("rsp1_data", rsp_q1, exp_q1.pop_front());
        chk("rsp1_latency", cyc, due_q1.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // stimulus
  initial begin
    int pool[8];
    int inst, addr, r;
    logic we;
    logic [7:0] mask;
    pool = '{0, 1, 2, 511, 512, 1023, 1024, 1535};
    n_checks = 0; n_fail = 0; cyc = 0;
    resetn = 1'b0;
    valid0 = 0; we0 = 0; addr0 = '0; mask0 = '0; d0 = '0;
    valid1 = 0; we1 = 0; addr1 = '0; mask1 = '0; d1 = '0;
    clear_models();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready0", ready0, 0); chk("reset_init0", init0, 0);
    chk("reset_rspv0", rsp_v0, 0);  chk("reset_rspq0", rsp_q0, 0);
    chk("reset_ready1", ready1, 0); chk("reset_init1", init1, 0);
    chk("reset_rspv1", rsp_v1, 0);  chk("reset_rspq1", rsp_q1, 0);

    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk);
    count_clear();

    req(0, 0, 'h3FF, 8'h00, 8'h00);
    req(1, 0, 'h3FF, 8'h00, 8'h00);
    req(0, 1, 'h1A5, 8'hFF, 8'hC3);
    req(0, 0, 'h1A5, 8'h00, 8'h00);
    req(0, 0, 'h3A5, 8'h00, 8'h00);
    req(0, 1, 'h200, 8'hFF, 8'hAA);
    req(0, 1, 'h200, 8'hF0, 8'h0F);
    req(0, 0, 'h200, 8'h00, 8'h00);
    req(0, 1, 'h1A5, 8'h00, 8'hFF);
    req(0, 0, 'h1A5, 8'h00, 8'h00);
    req(1, 1, 0, 8'hFF, 8'h11);
    req(1, 1, 1, 8'hFF, 8'h22);
    req(1, 1, 2, 8'hFF, 8'h33);
    req(1, 0, 0, 8'h00, 8'h00);
    req(1, 0, 1, 8'h00, 8'h00);
    req(1, 0, 2, 8'h00, 8'h00);
    req(1, 0, 'h600, 8'h00, 8'h00);
    req(1, 1, 'h600, 8'hFF, 8'h5A);
    req(1, 0, 'h600, 8'h00, 8'h00);
    req(1, 0, 0, 8'h00, 8'h00);
    req(1, 0, 512, 8'h00, 8'h00);
    req(1, 0, 1024, 8'h00, 8'h00);
    req(1, 0, 'h7FF, 8'h00, 8'h00);
    idle(4);

    for (int it = 0; it < 900; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) idle(1);
      else begin
        inst = $urandom_range(0, 1);
        we   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) addr = $urandom_range(0, 2047);
        else addr = pool[$urandom_range(0, 7)] + $urandom_range(0, 3);
        if (inst == 0) addr = addr % T0;
        case ($urandom_range(0, 3))
          0: mask = 8'hFF;
          1: mask = 8'h00;
          default: mask = 8'($urandom_range(0, 255));
        endcase
        req(inst, we, addr, mask, 8'($urandom_range(0, 255)));
      end
    end
    idle(5);

    // read in flight when reset hits: latency-1 response escapes, registered one is dropped
    valid0 = 1'b1; we0 = 1'b0; addr0 = 10'h1A5;
    exp_q0.push_back(mem0['h1A5]);
    due_q0.push_back(cyc + 1);
    valid1 = 1'b1; we1 = 1'b0; addr1 = 11'h001;
    @(posedge clk); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    resetn = 1'b0;
    idle(3);
    @(negedge clk);
    chk("flush_rspq1", rsp_q1, 0);
    chk("flush_rspq0", rsp_q0, 0);
    chk("flush_ready1", ready1, 0);
    @(posedge clk); #1;

    resetn = 1'b1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk);
    count_clear();
    clear_models();

    req(0, 0, 'h1A5, 8'h00, 8'h00);
    req(0, 0, 'h200, 8'h00, 8'h00);
    req(1, 0, 0, 8'h00, 8'h00);
    for (int it = 0; it < 200; it++) begin
      inst = $urandom_range(0, 1);
      addr = (inst == 0) ? $urandom_range(0, T0 - 1) : $urandom_range(0, 2047);
      we   = 1'($urandom_range(0, 3) == 0);
      req(inst, we, addr, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    idle(6);

    chk("drained0", exp_q0.size(), 0);
    chk("drained1", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
